// File: rtl/time_msg_tx_pkg.sv
// Shared definitions for the time message transmitter.
// Optional macro TIME_MSG_CRLF_EN adds a CR byte ahead of the line terminator.
package time_msg_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } stateT;

  localparam int unsigned MsgLenCrlf = 10;
  localparam int unsigned MsgLenLf   = 9;

`ifdef TIME_MSG_CRLF_EN
  localparam int unsigned MsgLen = MsgLenCrlf;
`else
  localparam int unsigned MsgLen = MsgLenLf;
`endif

  localparam logic [3:0] LastIdx = 4'(MsgLen - 1);

  localparam logic [7:0] AsciiZero  = 8'h30;
  localparam logic [7:0] AsciiColon = 8'h3A;
  localparam logic [7:0] AsciiCr    = 8'h0D;
  localparam logic [7:0] AsciiLf    = 8'h0A;

  // Invalid BCD collapses to '0' so the output is always a digit character.
  function automatic logic [7:0] encDigit(input logic [3:0] d);
    return (d <= 4'd9) ? (AsciiZero + {4'h0, d}) : AsciiZero;
  endfunction

endpackage

// File: rtl/time_msg_tx_enc.sv
// Encoder: one BCD digit to its ASCII character.
module time_msg_tx_enc
  import time_msg_tx_pkg::*;
(
  input  logic [3:0] iDigit,
  output logic [7:0] oAscii
);

  // Pure combinational lookup.
  always_comb begin
    oAscii = encDigit(iDigit);
  end

endmodule

// File: rtl/time_msg_tx.sv
// Time message transmitter: snapshots HH:MM:SS on start and pushes the ASCII
// line into the UART TX FIFO one byte per non-full cycle.
// Optional macro TIME_MSG_CRLF_EN emits CR before the line terminator.
module time_msg_tx
  import time_msg_tx_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = AsciiColon,
  parameter logic [7:0] EOL_CHAR = AsciiLf
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic [3:0] iHour10,
  input  logic [3:0] iHour1,
  input  logic [3:0] iMin10,
  input  logic [3:0] iMin1,
  input  logic [3:0] iSec10,
  input  logic [3:0] iSec1,
  input  logic       iFifoFull,
  output logic [7:0] oPushData,
  output logic       oPush,
  output logic       oBusy,
  output logic       oDone
);

  stateT            stateQ, stateD;
  logic [3:0]       idxQ, idxD;
  logic [5:0][3:0]  snapQ, snapD;
  logic [5:0][7:0]  encAscii;
  logic [7:0]       msgByte;

  // Six encoders, slot 0 = hour tens through slot 5 = second units.
  for (genvar g = 0; g < 6; g++) begin : gEnc
    time_msg_tx_enc uEnc (
      .iDigit (snapQ[g]),
      .oAscii (encAscii[g])
    );
  end

  // State, index and snapshot registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateQ <= StIdle;
      idxQ   <= 4'd0;
      snapQ  <= '0;
    end else begin
      stateQ <= stateD;
      idxQ   <= idxD;
      snapQ  <= snapD;
    end
  end

  // Byte selection by message index.
  always_comb begin
    msgByte = 8'h00;
    case (idxQ)
      4'd0: msgByte = encAscii[0];
      4'd1: msgByte = encAscii[1];
      4'd2: msgByte = SEP_CHAR;
      4'd3: msgByte = encAscii[2];
      4'd4: msgByte = encAscii[3];
      4'd5: msgByte = SEP_CHAR;
      4'd6: msgByte = encAscii[4];
      4'd7: msgByte = encAscii[5];
`ifdef TIME_MSG_CRLF_EN
      4'd8: msgByte = AsciiCr;
      4'd9: msgByte = EOL_CHAR;
`else
      4'd8: msgByte = EOL_CHAR;
`endif
      default: msgByte = 8'h00;
    endcase
  end

  // Next-state logic and outputs.
  always_comb begin
    stateD    = stateQ;
    idxD      = idxQ;
    snapD     = snapQ;
    oPush     = 1'b0;
    oPushData = 8'h00;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    case (stateQ)
      StIdle: begin
        if (iStart) begin
          snapD  = {iSec1, iSec10, iMin1, iMin10, iHour1, iHour10};
          idxD   = 4'd0;
          stateD = StSend;
        end
      end
      StSend: begin
        oBusy     = 1'b1;
        oPush     = ~iFifoFull;
        oPushData = msgByte;
        // A full FIFO holds index and data so nothing is dropped or repeated.
        if (!iFifoFull) begin
          if (idxQ == LastIdx) begin
            idxD   = 4'd0;
            stateD = StDone;
          end else begin
            idxD = idxQ + 4'd1;
          end
        end
      end
      StDone: begin
        oBusy  = 1'b1;
        oDone  = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

endmodule

// File: tb/tb_time_msg_tx.sv
// Self-checking bench for time_msg_tx: queue-based message model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_time_msg_tx;

  typedef logic [7:0] byteQ[$];

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iStart = 1'b0;
  logic [3:0] iHour10 = '0, iHour1 = '0, iMin10 = '0, iMin1 = '0, iSec10 = '0, iSec1 = '0;
  logic       iFifoFull = 1'b0;
  logic [7:0] oPushData;
  logic       oPush, oBusy, oDone;

  int nChecks = 0;
  int nFail = 0;
  int doneCnt = 0;
  byteQ capQ;

  // Model state: 0 idle, 1 sending, 2 done pulse.
  int   mState = 0;
  byteQ mQ;

  time_msg_tx dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iStart    (iStart),
    .iHour10   (iHour10),
    .iHour1    (iHour1),
    .iMin10    (iMin10),
    .iMin1     (iMin1),
    .iSec10    (iSec10),
    .iSec1     (iSec1),
    .iFifoFull (iFifoFull),
    .oPushData (oPushData),
    .oPush     (oPush),
    .oBusy     (oBusy),
    .oDone     (oDone)
  );

  always #5 iClk = ~iClk;

  function automatic void checkEq(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] enc(input logic [3:0] d);
    return (d <= 4'd9) ? 8'h30 + 8'(d) : 8'h30;
  endfunction

  function automatic byteQ buildMsg(input logic [3:0] h10, h1, m10, m1, s10, s1);
    byteQ q;
    q = {enc(h10), enc(h1), 8'h3A, enc(m10), enc(m1), 8'h3A, enc(s10), enc(s1)};
`ifdef TIME_MSG_CRLF_EN
    q.push_back(8'h0D);
`endif
    q.push_back(8'h0A);
    return q;
  endfunction

  // Compare DUT against the model away from the active edge, then advance it.
  always @(negedge iClk) begin
    if (!iRst_n) begin
      checkEq("rst_push", oPush, 0);
      checkEq("rst_data", oPushData, 0);
      checkEq("rst_busy", oBusy, 0);
      checkEq("rst_done", oDone, 0);
      mState = 0;
      mQ.delete();
    end else begin
      checkEq("push", oPush, (mState == 1) && !iFifoFull);
      checkEq("data", oPushData, (mState == 1) ? mQ[0] : 8'h00);
      checkEq("busy", oBusy, mState != 0);
      checkEq("done", oDone, mState == 2);
      if (oPush) capQ.push_back(oPushData);
      if (oDone) doneCnt++;
      case (mState)
        0: if (iStart) begin
          mQ = buildMsg(iHour10, iHour1, iMin10, iMin1, iSec10, iSec1);
          mState = 1;
        end
        1: if (!iFifoFull) begin
          void'(mQ.pop_front());
          if (mQ.size() == 0) mState = 2;
        end
        default: mState = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic setDigits(input logic [3:0] h10, h1, m10, m1, s10, s1);
    iHour10 = h10; iHour1 = h1; iMin10 = m10; iMin1 = m1; iSec10 = s10; iSec1 = s1;
  endtask

  task automatic pulseStart();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge iClk);
      if (oDone) seen = 1;
    end
    nChecks++;
    if (!seen) begin
      nFail++;
      $display("FAIL wait_done: no oDone within %0d cycles", budget);
    end
    tick();
  endtask

  task automatic checkCap(input string name, input byteQ exp);
    checkEq({name, "_len"}, capQ.size(), exp.size());
    for (int i = 0; i < exp.size() && i < capQ.size(); i++)
      checkEq(name, capQ[i], exp[i]);
  endtask

  initial begin
    byteQ lit;
`ifdef TIME_MSG_CRLF_EN
    lit = {8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
`else
    lit = {8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0A};
`endif

    // Reset held for three cycles, then twenty idle cycles.
    repeat (3) tick();
    iRst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkEq("idle_push", oPush, 0);
      checkEq("idle_busy", oBusy, 0);
    end

    // Plain message, no stall.
    setDigits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    capQ.delete(); doneCnt = 0;
    pulseStart();
    checkEq("first_push", oPush, 1);
    checkEq("first_data", oPushData, 8'h31);
    waitDone(40);
    checkCap("plain", lit);
    checkEq("plain_done_cnt", doneCnt, 1);

    // Backpressure during SEND cycles 3..5.
    capQ.delete(); doneCnt = 0;
    pulseStart();
    for (int c = 0; c < 9; c++) begin
      iFifoFull = (c >= 3 && c <= 5);
      #1;
      if (iFifoFull) begin
        checkEq("stall_push", oPush, 0);
        checkEq("stall_data", oPushData, 8'h33);
      end
      tick();
    end
    iFifoFull = 1'b0;
    waitDone(40);
    checkCap("stall", lit);
    checkEq("stall_done_cnt", doneCnt, 1);

    // New digits and a restart request mid-message are both ignored.
    capQ.delete(); doneCnt = 0;
    pulseStart();
    repeat (3) tick();
    setDigits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    pulseStart();
    waitDone(40);
    repeat (5) tick();
    checkCap("snap", lit);
    checkEq("snap_done_cnt", doneCnt, 1);

    // Invalid BCD maps to '0'.
    setDigits(4'hC, 4'd2, 4'd3, 4'd4, 4'd5, 4'hF);
    capQ.delete();
    pulseStart();
    waitDone(40);
    checkEq("inv_len", capQ.size(), lit.size());
    if (capQ.size() >= 8) begin
      checkEq("inv_b0", capQ[0], 8'h30);
      checkEq("inv_b1", capQ[1], 8'h32);
      checkEq("inv_b7", capQ[7], 8'h30);
    end

    // Asynchronous reset after four bytes, then a clean restart.
    setDigits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    capQ.delete();
    pulseStart();
    for (int i = 0; i < 30 && capQ.size() < 4; i++) tick();
    checkEq("pre_rst_busy", oBusy, 1);
    #2;
    iRst_n = 1'b0;
    #1;
    checkEq("arst_push", oPush, 0);
    checkEq("arst_data", oPushData, 0);
    checkEq("arst_busy", oBusy, 0);
    checkEq("arst_done", oDone, 0);
    tick(); tick();
    iRst_n = 1'b1;
    tick();
    capQ.delete(); doneCnt = 0;
    pulseStart();
    checkEq("restart_data", oPushData, 8'h31);
    waitDone(40);
    checkCap("restart", lit);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      iFifoFull = ($urandom_range(0, 3) == 0);
      iStart = ($urandom_range(0, 7) == 0);
      setDigits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom));
      tick();
    end
    iStart = 1'b0;
    iFifoFull = 1'b0;
    repeat (20) tick();
    checkEq("final_idle", oBusy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
